// File: rtl/tl_to_ahb_master_bridge.sv
// tl_to_ahb_master_bridge: turns single-beat TL-UL requests into NONSEQ SINGLE AHB-Lite transfers,
// one outstanding request at a time; unsupported requests are denied without touching the bus.
module tl_to_ahb_master_bridge #(
  parameter int          ADDR_W    = 32,
  parameter int          SRC_W     = 2,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [2:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_denied,
  output logic [31:0]       d_data,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [31:0]       hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [31:0]       hrdata
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;
  localparam logic [2:0] OP_GET = 3'd4;
  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d, size_q, size_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d, hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic                denied_q, denied_d, supported;
  // Byte lanes are implied by size/alignment on AHB, so the mask is not needed.
  logic                unused_mask;
  assign unused_mask = ^a_mask;
  assign supported = (a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == OP_GET) && a_size <= 3'd2;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    size_d   = size_q;
    src_d    = src_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    denied_d = denied_q;
    case (state_q)
      IDLE: if (a_valid && a_ready) begin
        op_d     = a_opcode;
        size_d   = a_size;
        src_d    = a_source;
        addr_d   = a_address;
        wdata_d  = a_data;
        rdata_d  = '0;
        denied_d = !supported;
        state_d  = supported ? ADDR : RESP;
      end
      ADDR: if (hready) begin
        state_d  = DATA;
        hwdata_d = (op_q != OP_GET) ? wdata_q : hwdata_q;
      end
      DATA: if (hready) begin
        state_d  = RESP;
        denied_d = hresp;
        rdata_d  = (op_q == OP_GET && !hresp) ? hrdata : '0;
      end
      RESP: if (d_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      size_q   <= '0;
      src_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      size_q   <= size_d;
      src_q    <= src_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      denied_q <= denied_d;
    end
  end
  // a_ready is gated by reset so it stays low while reset is held.
  assign a_ready  = (state_q == IDLE) && reset_n;
  assign d_valid  = state_q == RESP;
  assign d_opcode = (op_q == 3'd5) ? 3'd2 : (op_q >= 3'd2) ? 3'd1 : 3'd0;
  assign d_size   = size_q;
  assign d_source = src_q;
  assign d_denied = denied_q;
  assign d_data   = rdata_q;
  assign haddr    = addr_q;
  assign htrans   = (state_q == ADDR) ? 2'd2 : 2'd0;
  assign hwrite   = (state_q == ADDR) && (op_q != OP_GET);
  assign hsize    = size_q;
  assign hburst   = 3'd0;
  assign hprot    = HPROT_VAL;
  assign hwdata   = hwdata_q;
endmodule

// File: tb/tb_tl_to_ahb_master_bridge.sv
// tb_tl_to_ahb_master_bridge: directed checks of the TL-UL to AHB-Lite master bridge.
module tb_tl_to_ahb_master_bridge;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        a_valid = 1'b0, a_ready;
  logic [2:0]  a_opcode = '0, a_size = '0;
  logic [1:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = 4'hf;
  logic [31:0] a_data = '0;
  logic        d_valid, d_ready = 1'b1, d_denied;
  logic [2:0]  d_opcode, d_size;
  logic [1:0]  d_source;
  logic [31:0] d_data, haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hready = 1'b1, hresp = 1'b0;
  logic [31:0] hrdata = '0;
  int checks = 0, errors = 0;

  tl_to_ahb_master_bridge dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                      input logic [31:0] addr, input logic [31:0] data);
    a_opcode = op; a_size = sz; a_source = src; a_address = addr; a_data = data; a_valid = 1'b1;
    #1;
    chk("accept_ready", a_ready, 1);
    chk("accept_idle_htrans", htrans, 0);
    step();
    a_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_htrans", htrans, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_d_data", d_data, 0);
    step();
    reset_n = 1'b1;
    step();
    // Get, zero wait states
    hrdata = 32'hDEADBEEF;
    send(3'd4, 3'd2, 2'd1, 32'h2000_0004, 32'h0);
    chk("get_htrans", htrans, 2);
    chk("get_haddr", haddr, 32'h2000_0004);
    chk("get_hwrite", hwrite, 0);
    chk("get_hsize", hsize, 2);
    chk("get_hburst", hburst, 0);
    chk("get_hprot", hprot, 4'b0011);
    chk("get_addr_a_ready", a_ready, 0);
    step();
    chk("get_data_htrans", htrans, 0);
    chk("get_data_dvalid", d_valid, 0);
    step();
    chk("get_dvalid", d_valid, 1);
    chk("get_dopcode", d_opcode, 1);
    chk("get_ddata", d_data, 32'hDEADBEEF);
    chk("get_ddenied", d_denied, 0);
    chk("get_dsource", d_source, 1);
    chk("get_dsize", d_size, 2);
    chk("get_resp_a_ready", a_ready, 0);
    step();
    chk("get_done_dvalid", d_valid, 0);
    chk("get_done_a_ready", a_ready, 1);
    // PutFull with two data-phase wait states
    send(3'd0, 3'd2, 2'd2, 32'h1000, 32'h1234_5678);
    chk("put_htrans", htrans, 2);
    chk("put_hwrite", hwrite, 1);
    chk("put_haddr", haddr, 32'h1000);
    step();
    hready = 1'b0;
    chk("put_w0_hwdata", hwdata, 32'h1234_5678);
    chk("put_w0_htrans", htrans, 0);
    step();
    chk("put_w1_hwdata", hwdata, 32'h1234_5678);
    chk("put_w1_dvalid", d_valid, 0);
    step();
    hready = 1'b1;
    chk("put_w2_hwdata", hwdata, 32'h1234_5678);
    chk("put_w2_dvalid", d_valid, 0);
    step();
    chk("put_dvalid", d_valid, 1);
    chk("put_dopcode", d_opcode, 0);
    chk("put_ddata", d_data, 0);
    chk("put_ddenied", d_denied, 0);
    chk("put_dsource", d_source, 2);
    step();
    // Get with two-cycle ERROR response
    send(3'd4, 3'd2, 2'd0, 32'h3000, 32'h0);
    chk("err_htrans", htrans, 2);
    step();
    hresp = 1'b1; hready = 1'b0; hrdata = 32'hCAFE_F00D;
    #1;
    chk("err_c1_htrans", htrans, 0);
    step();
    hready = 1'b1;
    #1;
    chk("err_c2_htrans", htrans, 0);
    step();
    hresp = 1'b0;
    chk("err_dvalid", d_valid, 1);
    chk("err_ddenied", d_denied, 1);
    chk("err_ddata", d_data, 0);
    chk("err_dopcode", d_opcode, 1);
    chk("err_resp_htrans", htrans, 0);
    step();
    // Arith is unsupported: denied, no bus activity
    send(3'd2, 3'd2, 2'd3, 32'h5000, 32'h0);
    chk("arith_htrans", htrans, 0);
    chk("arith_dvalid", d_valid, 1);
    chk("arith_dopcode", d_opcode, 1);
    chk("arith_ddenied", d_denied, 1);
    chk("arith_dsource", d_source, 3);
    chk("arith_ddata", d_data, 0);
    step();
    // Intent answers HintAck
    send(3'd5, 3'd2, 2'd2, 32'h6000, 32'h0);
    chk("intent_htrans", htrans, 0);
    chk("intent_dopcode", d_opcode, 2);
    chk("intent_ddenied", d_denied, 1);
    step();
    // Oversized Get with D backpressure
    d_ready = 1'b0;
    send(3'd4, 3'd3, 2'd0, 32'h7000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("big_htrans", htrans, 0);
      chk("big_dvalid", d_valid, 1);
      chk("big_ddenied", d_denied, 1);
      chk("big_dopcode", d_opcode, 1);
      chk("big_dsize", d_size, 3);
      chk("big_ddata", d_data, 0);
      chk("big_a_ready", a_ready, 0);
      step();
    end
    d_ready = 1'b1;
    #1;
    chk("big_hs_dvalid", d_valid, 1);
    step();
    chk("big_done_dvalid", d_valid, 0);
    // Reset during the data phase
    send(3'd4, 3'd2, 2'd1, 32'h40, 32'h0);
    step();
    hready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_htrans", htrans, 0);
    chk("mid_rst_dvalid", d_valid, 0);
    chk("mid_rst_a_ready", a_ready, 0);
    step();
    chk("mid_rst_hold_htrans", htrans, 0);
    reset_n = 1'b1; hready = 1'b1; hrdata = 32'h0BAD_CAFE;
    step();
    send(3'd4, 3'd2, 2'd2, 32'h44, 32'h0);
    chk("post_htrans", htrans, 2);
    chk("post_haddr", haddr, 32'h44);
    step();
    step();
    chk("post_dvalid", d_valid, 1);
    chk("post_ddata", d_data, 32'h0BAD_CAFE);
    chk("post_ddenied", d_denied, 0);
    chk("post_dsource", d_source, 2);
    step();
    chk("post_done_a_ready", a_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
